// File: rtl/vec_pipe_stage.sv
// Elastic vector pipeline register: main + skid entry with valid/ready handshake,
// synchronous flush, per-lane zero masking at capture, and saturating stall/bubble counters.
module vec_pipe_stage #(
    parameter int CTRL_WIDTH    = 18,
    parameter int REGISTER_SIZE = 8,
    parameter int VECTOR_SIZE   = 4,
    parameter int NUM_OPERANDS  = 2,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        flush,
    input  logic                                                        cnt_clr,
    input  logic                                                        in_valid,
    output logic                                                        in_ready,
    input  logic [CTRL_WIDTH-1:0]                                       in_ctrl,
    input  logic [NUM_OPERANDS-1:0][VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] in_vec,
    input  logic [VECTOR_SIZE-1:0]                                      in_lane_mask,
    output logic                                                        out_valid,
    input  logic                                                        out_ready,
    output logic [CTRL_WIDTH-1:0]                                       out_ctrl,
    output logic [NUM_OPERANDS-1:0][VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] out_vec,
    output logic [VECTOR_SIZE-1:0]                                      out_lane_mask,
    output logic [1:0]                                                  occupancy,
    output logic [COUNT_WIDTH-1:0]                                      stall_count,
    output logic [COUNT_WIDTH-1:0]                                      bubble_count
);

    typedef logic [NUM_OPERANDS-1:0][VECTOR_SIZE-1:0][REGISTER_SIZE-1:0] vec_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   main_valid;
    logic                   skid_valid;
    logic [CTRL_WIDTH-1:0]  main_ctrl;
    vec_t                   main_vec;
    logic [VECTOR_SIZE-1:0] main_mask;
    logic [CTRL_WIDTH-1:0]  skid_ctrl;
    vec_t                   skid_vec;
    logic [VECTOR_SIZE-1:0] skid_mask;

    vec_t masked_vec;
    logic accept;
    logic drain;
    logic stall_cond;
    logic bubble_cond;

    // Inactive lanes are zeroed once at capture so downstream stages never see stale lane data.
    always_comb begin
        masked_vec = in_vec;
        for (int o = 0; o < NUM_OPERANDS; o++) begin
            for (int l = 0; l < VECTOR_SIZE; l++) begin
                if (!in_lane_mask[l]) begin
                    masked_vec[o][l] = '0;
                end
            end
        end
    end

    // in_ready only looks at registered state and flush, so it never forms a path from out_ready.
    assign in_ready    = !skid_valid && !flush;
    assign accept      = in_valid && in_ready;
    assign drain       = main_valid && out_ready;
    assign stall_cond  = main_valid && !out_ready;
    assign bubble_cond = out_ready && !main_valid;

    assign out_valid     = main_valid;
    assign out_ctrl      = main_ctrl;
    assign out_vec       = main_vec;
    assign out_lane_mask = main_mask;
    assign occupancy     = 2'(main_valid) + 2'(skid_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            main_vec   <= '0;
            main_mask  <= '0;
            skid_ctrl  <= '0;
            skid_vec   <= '0;
            skid_mask  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                main_ctrl  <= skid_ctrl;
                main_vec   <= skid_vec;
                main_mask  <= skid_mask;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_ctrl <= in_ctrl;
                main_vec  <= masked_vec;
                main_mask <= in_lane_mask;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_vec   <= masked_vec;
                main_mask  <= in_lane_mask;
            end else begin
                skid_valid <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_vec   <= masked_vec;
                skid_mask  <= in_lane_mask;
            end
        end
    end

    // Counters ignore flush: the flush cycle is judged on the pre-flush out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else if (cnt_clr) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (stall_cond && stall_count != CNT_MAX) begin
                stall_count <= stall_count + COUNT_WIDTH'(1);
            end
            if (bubble_cond && bubble_count != CNT_MAX) begin
                bubble_count <= bubble_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vec_pipe_stage.sv
// Bench for vec_pipe_stage: directed scenarios plus random traffic, checked against a
// two-deep queue model; a second instance with 3-bit counters covers saturation.
module tb_vec_pipe_stage;

    localparam int CW = 18;
    localparam int RS = 8;
    localparam int VS = 4;
    localparam int NO = 2;
    localparam int KW = 16;
    localparam int SW = 3;

    typedef logic [NO-1:0][VS-1:0][RS-1:0] vec_t;
    typedef struct packed {
        logic [CW-1:0] ctrl;
        vec_t          vec;
        logic [VS-1:0] mask;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    vec_t          in_vec = '0;
    logic [VS-1:0] in_lane_mask = '0;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    vec_t          out_vec;
    logic [VS-1:0] out_lane_mask;
    logic [1:0]    occupancy;
    logic [KW-1:0] stall_count, bubble_count;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    vec_t          s_out_vec;
    logic [VS-1:0] s_out_lane_mask;
    logic [1:0]    s_occupancy;
    logic [SW-1:0] s_stall_count, s_bubble_count;

    vec_pipe_stage #(.CTRL_WIDTH(CW), .REGISTER_SIZE(RS), .VECTOR_SIZE(VS),
                     .NUM_OPERANDS(NO), .COUNT_WIDTH(KW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_vec(in_vec),
        .in_lane_mask(in_lane_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_vec(out_vec), .out_lane_mask(out_lane_mask),
        .occupancy(occupancy), .stall_count(stall_count), .bubble_count(bubble_count));

    vec_pipe_stage #(.CTRL_WIDTH(CW), .REGISTER_SIZE(RS), .VECTOR_SIZE(VS),
                     .NUM_OPERANDS(NO), .COUNT_WIDTH(SW)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_vec(in_vec),
        .in_lane_mask(in_lane_mask), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_vec(s_out_vec), .out_lane_mask(s_out_lane_mask),
        .occupancy(s_occupancy), .stall_count(s_stall_count), .bubble_count(s_bubble_count));

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    ent_t q[$];
    int   m_stall, m_bubble, s_stall, s_bubble;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t mask_vec(input vec_t v, input logic [VS-1:0] m);
        vec_t r = v;
        for (int o = 0; o < NO; o++)
            for (int l = 0; l < VS; l++)
                if (!m[l]) r[o][l] = '0;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_stall = 0; m_bubble = 0; s_stall = 0; s_bubble = 0;
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !flush));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        if (q.size() > 0) begin
            chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
            chk("out_vec", 64'(out_vec), 64'(q[0].vec));
            chk("out_lane_mask", 64'(out_lane_mask), 64'(q[0].mask));
        end
        chk("stall_count", 64'(stall_count), 64'(m_stall));
        chk("bubble_count", 64'(bubble_count), 64'(m_bubble));
        chk("sat_out_valid", 64'(s_out_valid), 64'(q.size() > 0));
        chk("sat_stall_count", 64'(s_stall_count), 64'(s_stall));
        chk("sat_bubble_count", 64'(s_bubble_count), 64'(s_bubble));
    endtask

    // One cycle: check mid-cycle, advance the model with the current inputs, cross the edge.
    task automatic step();
        bit   has, drain, acc, stl, bub;
        ent_t e;
        #3;
        check_all();
        has   = q.size() > 0;
        drain = has && out_ready;
        acc   = in_valid && (q.size() < 2) && !flush;
        stl   = has && !out_ready;
        bub   = out_ready && !has;
        if (cnt_clr) begin
            m_stall = 0; m_bubble = 0; s_stall = 0; s_bubble = 0;
        end else begin
            if (stl && m_stall < (1 << KW) - 1) m_stall++;
            if (bub && m_bubble < (1 << KW) - 1) m_bubble++;
            if (stl && s_stall < (1 << SW) - 1) s_stall++;
            if (bub && s_bubble < (1 << SW) - 1) s_bubble++;
        end
        if (drain) void'(q.pop_front());
        if (flush) q.delete();
        else if (acc) begin
            e.ctrl = in_ctrl;
            e.vec  = mask_vec(in_vec, in_lane_mask);
            e.mask = in_lane_mask;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input vec_t d,
                         input logic [VS-1:0] m, input logic ordy, input logic fl,
                         input logic clr);
        in_valid = v; in_ctrl = c; in_vec = d; in_lane_mask = m;
        out_ready = ordy; flush = fl; cnt_clr = clr;
        step();
    endtask

    function automatic vec_t rvec();
        return vec_t'({$urandom(), $urandom()});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_out_vec", 64'(out_vec), 64'(0));
        chk("rst_out_mask", 64'(out_lane_mask), 64'(0));
        chk("rst_counts", 64'({stall_count, bubble_count}), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) drive(1'b1, CW'(i), rvec(), '1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("stream_stall", 64'(stall_count), 64'(0));

        // Backpressure fills main and skid, then drains in order
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, CW'('hA), rvec(), '1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, CW'('hB), rvec(), '1, 1'b0, 1'b0, 1'b0);
        chk("bp_occupancy", 64'(occupancy), 64'(2));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        drive(1'b1, CW'('hC), rvec(), '1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp_head_a", 64'(out_ctrl), 64'('hA));
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_head_b", 64'(out_ctrl), 64'('hB));
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_stall", 64'(stall_count), 64'(3));
        chk("bp_empty", 64'(out_valid), 64'(0));

        // Lane masking
        drive(1'b1, CW'('h55), '1, 4'b1010, 1'b1, 1'b0, 1'b0);
        #3;
        chk("mask_vec", 64'(out_vec), 64'hFF00FF00FF00FF00);
        chk("mask_keep", 64'(out_lane_mask), 64'(4'b1010));
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with both entries held and a new entry presented
        drive(1'b1, CW'('hC1), rvec(), '1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, CW'('hD2), rvec(), '1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, CW'('hE3), rvec(), '1, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_occ", 64'(occupancy), 64'(0));
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Counter saturation on the 3-bit instance
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("sat_bubble_7", 64'(s_bubble_count), 64'(7));
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("clr_bubble_0", 64'(s_bubble_count), 64'(0));

        // Asynchronous reset with an entry held at the output
        drive(1'b1, CW'('hF7), rvec(), '1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_arst_valid", 64'(out_valid), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_occ", 64'(occupancy), 64'(0));
        chk("arst_ctrl", 64'(out_ctrl), 64'(0));
        chk("arst_vec", 64'(out_vec), 64'(0));
        chk("arst_counts", 64'({stall_count, bubble_count}), 64'(0));
        model_reset();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), CW'($urandom()), rvec(), VS'($urandom()),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 39) == 0));
        end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
